// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory op encodings, FSM states and
// per-op helpers (byte count, load/store classification).
package mem_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int MEM_OP_W  = 4;

    localparam logic [DATA_W-1:0] ZERO32 = '0;

    typedef enum logic [MEM_OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Index of the final byte of the access (byte count minus one).
    function automatic logic [1:0] op_last_byte(input logic [MEM_OP_W-1:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_SW:         return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the byte-assembled load word according to the op.
import mem_stage_pkg::*;

module mem_load_ext (
    input  logic [MEM_OP_W-1:0] op,
    input  logic [DATA_W-1:0]   word,
    output logic [DATA_W-1:0]   value
);

    always_comb begin
        value = ZERO32;
        case (op)
            OP_LB:   value = {{24{word[7]}}, word[7:0]};
            OP_LBU:  value = {24'd0, word[7:0]};
            OP_LH:   value = {{16{word[15]}}, word[15:0]};
            OP_LHU:  value = {16'd0, word[15:0]};
            OP_LW:   value = word;
            default: value = ZERO32;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: pass-through for ALU ops, byte-serial little-endian
// loads/stores over an 8-bit controller port with a pipeline stall.
import mem_stage_pkg::*;

module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdE_in,
    input  logic [REG_IDX_W-1:0]  rdIdx_in,
    input  logic [DATA_W-1:0]     rdData_in,
    input  logic [MEM_OP_W-1:0]   memOp_in,
    input  logic [DATA_W-1:0]     storeData_in,
    output logic                  memReq_out,
    output logic                  memWE_out,
    output logic [ADDR_WIDTH-1:0] memAddr_out,
    output logic [7:0]            memData_out,
    input  logic [7:0]            memData_in,
    input  logic                  memAck_in,
    output logic                  stall_out,
    output logic                  rdE_out,
    output logic [REG_IDX_W-1:0]  rdIdx_out,
    output logic [DATA_W-1:0]     rdData_out
);

    state_t                state;
    state_t                state_next;
    logic [MEM_OP_W-1:0]   op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]     store_q;
    logic                  rde_q;
    logic [REG_IDX_W-1:0]  idx_q;
    logic [1:0]            cnt;
    logic [DATA_W-1:0]     asm_q;
    logic [DATA_W-1:0]     load_value;
    logic                  op_valid;
    logic                  last_byte;

    // Undefined op codes fall out of both classes and behave as NONE.
    assign op_valid  = op_is_load(memOp_in) || op_is_store(memOp_in);
    assign last_byte = (cnt == op_last_byte(op_q));

    mem_load_ext u_load_ext (
        .op    (op_q),
        .word  (asm_q),
        .value (load_value)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            op_q    <= OP_NONE;
            addr_q  <= '0;
            store_q <= '0;
            rde_q   <= 1'b0;
            idx_q   <= '0;
            cnt     <= 2'd0;
            asm_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_q    <= memOp_in;
                        addr_q  <= rdData_in[ADDR_WIDTH-1:0];
                        store_q <= storeData_in;
                        rde_q   <= rdE_in;
                        idx_q   <= rdIdx_in;
                        cnt     <= 2'd0;
                        asm_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (memAck_in) begin
                        if (op_is_load(op_q)) begin
                            asm_q[{cnt, 3'b000} +: 8] <= memData_in;
                        end
                        if (!last_byte) begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        memReq_out  = 1'b0;
        memWE_out   = 1'b0;
        memAddr_out = '0;
        memData_out = 8'd0;
        stall_out   = 1'b0;
        rdE_out     = 1'b0;
        rdIdx_out   = '0;
        rdData_out  = ZERO32;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    stall_out  = 1'b1;
                    state_next = ST_BUSY;
                end else begin
                    rdE_out    = rdE_in;
                    rdIdx_out  = rdIdx_in;
                    rdData_out = rdData_in;
                end
            end
            ST_BUSY: begin
                stall_out   = 1'b1;
                memReq_out  = 1'b1;
                memWE_out   = op_is_store(op_q);
                memAddr_out = addr_q + ADDR_WIDTH'(cnt);
                memData_out = store_q[{cnt, 3'b000} +: 8];
                if (memAck_in && last_byte) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // EX/MEM advances on this edge, so returning to IDLE cannot re-issue.
                rdIdx_out  = idx_q;
                rdE_out    = rde_q && op_is_load(op_q);
                rdData_out = load_value;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through, loads with extension, delayed
// stores, address wrap and reset in the middle of an access.
import mem_stage_pkg::*;

module tb_mem_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rdData_in;
    logic [3:0]  memOp_in;
    logic [31:0] storeData_in;
    logic        memReq_out;
    logic        memWE_out;
    logic [31:0] memAddr_out;
    logic [7:0]  memData_out;
    logic [7:0]  memData_in;
    logic        memAck_in;
    logic        stall_out;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdE_in       (rdE_in),
        .rdIdx_in     (rdIdx_in),
        .rdData_in    (rdData_in),
        .memOp_in     (memOp_in),
        .storeData_in (storeData_in),
        .memReq_out   (memReq_out),
        .memWE_out    (memWE_out),
        .memAddr_out  (memAddr_out),
        .memData_out  (memData_out),
        .memData_in   (memData_in),
        .memAck_in    (memAck_in),
        .stall_out    (stall_out),
        .rdE_out      (rdE_out),
        .rdIdx_out    (rdIdx_out),
        .rdData_out   (rdData_out)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memOp_in     = OP_NONE;
        rdE_in       = 1'b0;
        rdIdx_in     = 5'd0;
        rdData_in    = 32'd0;
        storeData_in = 32'd0;
        memAck_in    = 1'b0;
        memData_in   = 8'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(memReq_out),  32'd0);
        check({tag, "_we"},    32'(memWE_out),   32'd0);
        check({tag, "_addr"},  memAddr_out,      32'd0);
        check({tag, "_wdata"}, 32'(memData_out), 32'd0);
        check({tag, "_stall"}, 32'(stall_out),   32'd0);
        check({tag, "_rde"},   32'(rdE_out),     32'd0);
        check({tag, "_rdidx"}, 32'(rdIdx_out),   32'd0);
        check({tag, "_rddata"}, rdData_out,      32'd0);
    endtask

    // Issues one memory op at a negedge while in IDLE and plays the controller:
    // each byte is acked after 'delay' waiting cycles, read bytes from rbytes.
    task automatic do_mem_op(input string tag, input logic [3:0] op,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rbytes, input int nbytes,
                             input int delay, input logic is_store,
                             input logic [31:0] exp_rd);
        logic [31:0] exp_addr;
        int          stall_cnt;
        memOp_in     = op;
        rdData_in    = addr;
        storeData_in = sdata;
        rdE_in       = 1'b1;
        rdIdx_in     = 5'd7;
        #1;
        check({tag, "_issue_stall"}, 32'(stall_out), 32'd1);
        check({tag, "_issue_rde"},   32'(rdE_out),   32'd0);
        check({tag, "_issue_rd"},    rdData_out,     32'd0);
        stall_cnt = 1;
        for (int i = 0; i < nbytes; i++) exp_q.push_back(addr + 32'(i));
        for (int i = 0; i < nbytes; i++) begin
            exp_addr = exp_q.pop_front();
            for (int w = 0; w <= delay; w++) begin
                @(negedge clk_in);
                memAck_in = 1'b0;
                if (stall_out) stall_cnt++;
                check({tag, "_req"},  32'(memReq_out), 32'd1);
                check({tag, "_addr"}, memAddr_out,     exp_addr);
                check({tag, "_we"},   32'(memWE_out),  32'(is_store));
                if (is_store) check({tag, "_wdata"}, 32'(memData_out), 32'(sdata[8*i +: 8]));
                if (w == delay) begin
                    memAck_in  = 1'b1;
                    memData_in = rbytes[8*i +: 8];
                end
            end
        end
        @(negedge clk_in);
        memAck_in = 1'b0;
        check({tag, "_done_stall"}, 32'(stall_out),  32'd0);
        check({tag, "_done_req"},   32'(memReq_out), 32'd0);
        check({tag, "_done_rdidx"}, 32'(rdIdx_out),  32'd7);
        check({tag, "_done_rde"},   32'(rdE_out),    is_store ? 32'd0 : 32'd1);
        if (!is_store) check({tag, "_done_rd"}, rdData_out, exp_rd);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(1 + nbytes * (delay + 1)));
        idle_inputs();
        @(negedge clk_in);
        check({tag, "_back_idle"}, 32'(stall_out), 32'd0);
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // Pass-through, including an undefined op code.
        memOp_in = OP_NONE; rdE_in = 1'b1; rdIdx_in = 5'd5; rdData_in = 32'h1234;
        #1;
        check("pass_rde",   32'(rdE_out),    32'd1);
        check("pass_rdidx", 32'(rdIdx_out),  32'd5);
        check("pass_rd",    rdData_out,      32'h1234);
        check("pass_stall", 32'(stall_out),  32'd0);
        check("pass_req",   32'(memReq_out), 32'd0);
        memOp_in = 4'hF; rdData_in = 32'hCAFE0001;
        #1;
        check("undef_rd",    rdData_out,     32'hCAFE0001);
        check("undef_stall", 32'(stall_out), 32'd0);
        @(negedge clk_in);
        check("undef_no_req", 32'(memReq_out), 32'd0);
        idle_inputs();
        @(negedge clk_in);

        do_mem_op("lw",   OP_LW,  32'h100, 32'h0, 32'h12345678, 4, 0, 1'b0, 32'h12345678);
        do_mem_op("lb",   OP_LB,  32'h20,  32'h0, 32'h00000080, 1, 0, 1'b0, 32'hFFFFFF80);
        do_mem_op("lbu",  OP_LBU, 32'h20,  32'h0, 32'h00000080, 1, 0, 1'b0, 32'h00000080);
        do_mem_op("lh",   OP_LH,  32'h21,  32'h0, 32'h0000FFFE, 2, 0, 1'b0, 32'hFFFFFFFE);
        do_mem_op("lhu",  OP_LHU, 32'h22,  32'h0, 32'h00008001, 2, 1, 1'b0, 32'h00008001);
        do_mem_op("sh",   OP_SH,  32'h30,  32'hAABBCCDD, 32'h0, 2, 3, 1'b1, 32'h0);
        do_mem_op("sb",   OP_SB,  32'h44,  32'h11223344, 32'h0, 1, 0, 1'b1, 32'h0);
        do_mem_op("sw",   OP_SW,  32'h50,  32'h89ABCDEF, 32'h0, 4, 1, 1'b1, 32'h0);
        do_mem_op("wrap", OP_LW,  32'hFFFFFFFE, 32'h0, 32'hA1B2C3D4, 4, 0, 1'b0, 32'hA1B2C3D4);

        // Reset after the first of four LW acks.
        memOp_in = OP_LW; rdData_in = 32'h200; rdE_in = 1'b1; rdIdx_in = 5'd7;
        @(negedge clk_in);
        check("rst_mid_addr0", memAddr_out, 32'h200);
        memAck_in = 1'b1; memData_in = 8'h11;
        @(negedge clk_in);
        memAck_in = 1'b0;
        check("rst_mid_addr1", memAddr_out, 32'h201);
        idle_inputs();
        rst_in = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("rst_mid");
        rst_in    = 1'b0;
        memAck_in = 1'b1;
        memData_in = 8'h5A;
        @(negedge clk_in);
        memAck_in = 1'b0;
        check("stray_ack_stall", 32'(stall_out),  32'd0);
        check("stray_ack_req",   32'(memReq_out), 32'd0);
        @(negedge clk_in);
        check("stray_ack_req2",  32'(memReq_out), 32'd0);
        do_mem_op("lw_after_rst", OP_LW, 32'h40, 32'h0, 32'hDEADBEEF, 4, 0, 1'b0, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
